// File: rtl/wb_stage_if.sv
// wb_stage_if -- MEM-to-WB stage bundle.
//   Carries the instruction presented by the MEM stage, the load response
//   channel, and the register-file write port produced by the WB stage.
//   master : upstream / memory side (drives instruction and load response)
//   slave  : the writeback stage (drives write port, stall and status)
interface wb_stage_if;
   logic        mem_valid;
   logic        wb_en_in;
   logic        mem_r_en_in;
   logic [3:0]  dest_in;
   logic [31:0] alu_res_in;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic        WBWriteEnable;
   logic [3:0]  WBDest;
   logic [31:0] WBValue;
   logic        stall;
   logic [15:0] retire_count;
   logic        wb_timeout;

   modport master (
      output mem_valid, wb_en_in, mem_r_en_in, dest_in, alu_res_in,
      output mem_rdata, mem_rvalid,
      input  WBWriteEnable, WBDest, WBValue, stall, retire_count, wb_timeout
   );

   modport slave (
      input  mem_valid, wb_en_in, mem_r_en_in, dest_in, alu_res_in,
      input  mem_rdata, mem_rvalid,
      output WBWriteEnable, WBDest, WBValue, stall, retire_count, wb_timeout
   );
endinterface

// File: rtl/wb_stage.sv
// wb_stage -- pipeline writeback stage.
//   Writes ALU results straight through with one cycle of latency and holds
//   loads in LOAD_WAIT until the memory response arrives or the wait budget
//   of TIMEOUT cycles expires (abort, no write, sticky wb_timeout).
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : wb_stage_if.slave -- instruction in, load response in,
//          register-file write port, stall, retire_count, wb_timeout out
module wb_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input logic       clk,
   input logic       rst,
   wb_stage_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      LOAD_WAIT = 1'b1
   } state_t;

   // Last counter value before the load is abandoned.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_r, state_s;
   logic [7:0]  wait_cnt_r, wait_cnt_s;
   logic [3:0]  dest_lat_r, dest_lat_s;
   logic        wben_lat_r, wben_lat_s;
   logic        wr_en_r, wr_en_s;
   logic [3:0]  wr_dest_r, wr_dest_s;
   logic [31:0] wr_val_r, wr_val_s;
   logic [15:0] retire_r;
   logic        retire_s;
   logic        timeout_r;
   logic        timeout_set_s;
   logic        stall_s;

   // Next-state, write-port and stall decode.
   always_comb begin
      state_s       = state_r;
      wait_cnt_s    = wait_cnt_r;
      dest_lat_s    = dest_lat_r;
      wben_lat_s    = wben_lat_r;
      wr_en_s       = 1'b0;
      wr_dest_s     = wr_dest_r;
      wr_val_s      = wr_val_r;
      retire_s      = 1'b0;
      timeout_set_s = 1'b0;
      stall_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.mem_valid) begin
               if (bus.mem_r_en_in) begin
                  if (bus.mem_rvalid) begin
                     // Load with data already present: no wait needed.
                     wr_en_s  = bus.wb_en_in;
                     retire_s = 1'b1;
                     if (bus.wb_en_in) begin
                        wr_dest_s = bus.dest_in;
                        wr_val_s  = bus.mem_rdata;
                     end else begin
                        wr_dest_s = wr_dest_r;
                     end
                  end else begin
                     stall_s    = 1'b1;
                     dest_lat_s = bus.dest_in;
                     wben_lat_s = bus.wb_en_in;
                     wait_cnt_s = 8'd0;
                     state_s    = LOAD_WAIT;
                  end
               end else begin
                  wr_en_s  = bus.wb_en_in;
                  retire_s = 1'b1;
                  // Write index/data only move on a real write so they hold otherwise.
                  if (bus.wb_en_in) begin
                     wr_dest_s = bus.dest_in;
                     wr_val_s  = bus.alu_res_in;
                  end else begin
                     wr_dest_s = wr_dest_r;
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         LOAD_WAIT: begin
            stall_s = 1'b1;
            if (bus.mem_rvalid) begin
               // Data wins even on the final wait cycle.
               wr_en_s  = wben_lat_r;
               retire_s = 1'b1;
               state_s  = IDLE;
               if (wben_lat_r) begin
                  wr_dest_s = dest_lat_r;
                  wr_val_s  = bus.mem_rdata;
               end else begin
                  wr_dest_s = wr_dest_r;
               end
            end else if (wait_cnt_r == WAIT_LAST) begin
               timeout_set_s = 1'b1;
               retire_s      = 1'b1;
               state_s       = IDLE;
            end else begin
               wait_cnt_s = wait_cnt_r + 8'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, latched load context and registered write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         wait_cnt_r <= 8'd0;
         dest_lat_r <= 4'd0;
         wben_lat_r <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_dest_r  <= 4'd0;
         wr_val_r   <= 32'd0;
         retire_r   <= 16'd0;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         wait_cnt_r <= wait_cnt_s;
         dest_lat_r <= dest_lat_s;
         wben_lat_r <= wben_lat_s;
         wr_en_r    <= wr_en_s;
         wr_dest_r  <= wr_dest_s;
         wr_val_r   <= wr_val_s;
         retire_r   <= retire_r + {15'd0, retire_s};
         timeout_r  <= timeout_r | timeout_set_s;
      end
   end

   assign bus.WBWriteEnable = wr_en_r;
   assign bus.WBDest        = wr_dest_r;
   assign bus.WBValue       = wr_val_r;
   assign bus.retire_count  = retire_r;
   assign bus.wb_timeout    = timeout_r;
   assign bus.stall         = stall_s;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage -- directed bench for wb_stage (TIMEOUT=4).
//   Stimulus pushes the expected {dest, value} of every write into a queue;
//   a monitor on the falling edge pops and compares on each WBWriteEnable.
module tb_wb_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [35:0] exp_q[$];

   wb_stage_if bus();

   wb_stage #(.TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic re, input logic [3:0] d,
                        input logic [31:0] alu, input logic rv, input logic [31:0] rd);
      bus.mem_valid   = v;
      bus.wb_en_in    = we;
      bus.mem_r_en_in = re;
      bus.dest_in     = d;
      bus.alu_res_in  = alu;
      bus.mem_rvalid  = rv;
      bus.mem_rdata   = rd;
   endtask

   task automatic expect_write(input logic [3:0] d, input logic [31:0] v);
      exp_q.push_back({d, v});
   endtask

   // Write monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.WBWriteEnable === 1'b1) begin
         logic [35:0] e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got dest %h value %h expected no write",
                     bus.WBDest, bus.WBValue);
         end else begin
            e = exp_q.pop_front();
            if ({bus.WBDest, bus.WBValue} !== e) begin
               errors++;
               $display("FAIL write_data: got dest %h value %h expected dest %h value %h",
                        bus.WBDest, bus.WBValue, e[35:32], e[31:0]);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_we",      {31'd0, bus.WBWriteEnable}, 32'd0);
      check("reset_dest",    {28'd0, bus.WBDest}, 32'd0);
      check("reset_value",   bus.WBValue, 32'd0);
      check("reset_retire",  {16'd0, bus.retire_count}, 32'd0);
      check("reset_timeout", {31'd0, bus.wb_timeout}, 32'd0);
      check("reset_stall",   {31'd0, bus.stall}, 32'd0);

      // Single ALU op.
      drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h1234, 1'b0, 32'd0);
      expect_write(4'd3, 32'h1234);
      #1 check("alu_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("alu_we",     {31'd0, bus.WBWriteEnable}, 32'd1);
      check("alu_retire", {16'd0, bus.retire_count}, 32'd1);
      tick();
      check("alu_we_drop",    {31'd0, bus.WBWriteEnable}, 32'd0);
      check("alu_dest_hold",  {28'd0, bus.WBDest}, 32'd3);
      check("alu_value_hold", bus.WBValue, 32'h1234);

      // Back-to-back ALU ops, including index 15.
      drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h1111_0001, 1'b0, 32'd0);
      expect_write(4'd1, 32'h1111_0001);
      tick();
      drive(1'b1, 1'b1, 1'b0, 4'd2, 32'h2222_0002, 1'b0, 32'd0);
      expect_write(4'd2, 32'h2222_0002);
      tick();
      drive(1'b1, 1'b1, 1'b0, 4'd15, 32'hFFFF_000F, 1'b0, 32'd0);
      expect_write(4'd15, 32'hFFFF_000F);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("b2b_retire", {16'd0, bus.retire_count}, 32'd4);

      // Load with data in the same cycle: no stall, rdata written.
      drive(1'b1, 1'b1, 1'b1, 4'd5, 32'h0000_0055, 1'b1, 32'hCAFE_F00D);
      expect_write(4'd5, 32'hCAFE_F00D);
      #1 check("same_cycle_stall", {31'd0, bus.stall}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("same_cycle_retire", {16'd0, bus.retire_count}, 32'd5);

      // Stray rvalid in IDLE is ignored.
      drive(1'b0, 1'b0, 1'b0, 4'd6, 32'd0, 1'b1, 32'h0BAD_0BAD);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("stray_rvalid_retire", {16'd0, bus.retire_count}, 32'd5);

      // Load held for three stalled cycles; data arrives in the third.
      drive(1'b1, 1'b1, 1'b1, 4'd7, 32'd0, 1'b0, 32'd0);
      #1 check("load_stall_c0", {31'd0, bus.stall}, 32'd1);
      tick();
      #1 check("load_stall_c1", {31'd0, bus.stall}, 32'd1);
      tick();
      drive(1'b1, 1'b1, 1'b1, 4'd7, 32'd0, 1'b1, 32'hDEAD_BEEF);
      expect_write(4'd7, 32'hDEAD_BEEF);
      #1 check("load_stall_c2", {31'd0, bus.stall}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      #1 check("load_stall_release", {31'd0, bus.stall}, 32'd0);
      check("load_retire", {16'd0, bus.retire_count}, 32'd6);

      // Timeout: four wait cycles with no data abort the load.
      drive(1'b1, 1'b1, 1'b1, 4'd9, 32'd0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         #1 check("timeout_wait_stall", {31'd0, bus.stall}, 32'd1);
         check("timeout_not_yet", {31'd0, bus.wb_timeout}, 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      #1 check("timeout_stall_release", {31'd0, bus.stall}, 32'd0);
      check("timeout_flag",   {31'd0, bus.wb_timeout}, 32'd1);
      check("timeout_retire", {16'd0, bus.retire_count}, 32'd7);

      // Data arriving on the last wait cycle is still written.
      drive(1'b1, 1'b1, 1'b1, 4'd10, 32'd0, 1'b0, 32'd0);
      tick();
      repeat (3) tick();
      drive(1'b1, 1'b1, 1'b1, 4'd10, 32'd0, 1'b1, 32'h0A0A_0A0A);
      expect_write(4'd10, 32'h0A0A_0A0A);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("last_cycle_retire", {16'd0, bus.retire_count}, 32'd8);

      // ALU op after a timeout; flag stays set.
      drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h0000_0ABC, 1'b0, 32'd0);
      expect_write(4'd4, 32'h0000_0ABC);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("post_timeout_retire", {16'd0, bus.retire_count}, 32'd9);
      check("timeout_sticky", {31'd0, bus.wb_timeout}, 32'd1);

      // Reset while waiting, with data arriving in the same cycle.
      drive(1'b1, 1'b1, 1'b1, 4'd11, 32'd0, 1'b0, 32'd0);
      tick();
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1, 4'd11, 32'd0, 1'b1, 32'h1357_9BDF);
      tick();
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      #1 check("rst_wait_stall", {31'd0, bus.stall}, 32'd0);
      check("rst_wait_we",      {31'd0, bus.WBWriteEnable}, 32'd0);
      check("rst_wait_dest",    {28'd0, bus.WBDest}, 32'd0);
      check("rst_wait_value",   bus.WBValue, 32'd0);
      check("rst_wait_retire",  {16'd0, bus.retire_count}, 32'd0);
      check("rst_wait_timeout", {31'd0, bus.wb_timeout}, 32'd0);
      tick();
      check("rst_wait_idle_stall", {31'd0, bus.stall}, 32'd0);

      // Retire counter wrap using non-writing stores.
      drive(1'b1, 1'b0, 1'b0, 4'd8, 32'h5A5A_5A5A, 1'b0, 32'd0);
      repeat (65535) tick();
      check("wrap_full", {16'd0, bus.retire_count}, 32'h0000_FFFF);
      check("store_no_write", {31'd0, bus.WBWriteEnable}, 32'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
      check("wrap_zero", {16'd0, bus.retire_count}, 32'd0);
      check("wrap_store_we", {31'd0, bus.WBWriteEnable}, 32'd0);
      tick();
      tick();

      check("pending_writes", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning the number of LOAD_WAIT cycles without mem_rvalid before the load is aborted; the legal range is 2..255.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 mem_valid  input  1  an instruction from the MEM stage is presented this cycle.
REQ-005 wb_en_in  input  1  the presented instruction writes a register.
REQ-006 mem_r_en_in  input  1  the presented instruction is a load; its writeback value comes from mem_rdata.
REQ-007 dest_in  input  4  destination register index.
REQ-008 alu_res_in  input  32  ALU result, used as the writeback value for non-load instructions.
REQ-009 mem_rdata  input  32  load response data.
REQ-010 mem_rvalid  input  1  mem_rdata is valid this cycle.
REQ-011 WBWriteEnable  output  1  register-file write strobe, registered, single-cycle pulse.
REQ-012 WBDest  output  4  register-file write index, registered.
REQ-013 WBValue  output  32  register-file write data, registered.
REQ-014 stall  output  1  combinational back-pressure; upstream holds all MEM-stage inputs while this signal is high.
REQ-015 retire_count  output  16  registered count of retired instructions.
REQ-016 wb_timeout  output  1  sticky flag set when a load is aborted by timeout.

Function
REQ-017 The block SHALL implement two states: IDLE and LOAD_WAIT.
REQ-018 In IDLE, an instruction is accepted when mem_valid=1 and stall=0.
  - Non-load accepted (mem_r_en_in=0): WBWriteEnable=wb_en_in, WBDest=dest_in, WBValue=alu_res_in on the next edge.
REQ-019 In IDLE, with mem_valid=1, mem_r_en_in=1 and mem_rvalid=1 in the same cycle, the load SHALL be accepted and written back on the next edge, with WBValue=mem_rdata and WBWriteEnable=wb_en_in.
REQ-020 In IDLE, with mem_valid=1, mem_r_en_in=1 and mem_rvalid=0:
  - stall=1 combinationally;
  - on the edge, dest_in and wb_en_in are latched, the wait counter is cleared, and the state becomes LOAD_WAIT;
  - no write occurs that cycle.
REQ-021 stall SHALL equal (state==LOAD_WAIT) OR (state==IDLE AND mem_valid AND mem_r_en_in AND NOT mem_rvalid).
REQ-022 In LOAD_WAIT, mem_valid SHALL be ignored, and each cycle without mem_rvalid increments the wait counter.
REQ-023 In LOAD_WAIT, on mem_rvalid=1 the next edge SHALL produce:
  - WBWriteEnable = latched wb_en;
  - WBDest = latched dest;
  - WBValue = mem_rdata;
  - return to IDLE, with stall deasserted in the cycle after the write.
REQ-024 Timeout: if mem_rvalid=1 arrives in the cycle where the wait counter equals TIMEOUT-1, the data SHALL be written (data wins).
REQ-025 Timeout: if the wait counter reaches TIMEOUT-1 with mem_rvalid=0, the next edge SHALL:
  - perform no write;
  - set wb_timeout=1;
  - retire the instruction;
  - return to IDLE.
REQ-026 mem_rvalid while in IDLE with no load presented SHALL be ignored.
REQ-027 WBWriteEnable SHALL be high for exactly one cycle per written instruction and low in every other cycle; WBDest and WBValue hold their last values when WBWriteEnable=0.
REQ-028 dest_in=15 SHALL be written like any other index; PC handling is outside this block.
REQ-029 retire_count SHALL increment by 1 on each completed instruction (write, no-write, or timeout abort) and wrap from 16'hFFFF to 16'h0000.
REQ-030 The latency from acceptance (or data arrival) to WBWriteEnable SHALL be exactly 1 cycle; throughput is one non-load instruction per cycle.

Reset
REQ-031 With rst=1 at an edge, the block SHALL go to IDLE and clear WBWriteEnable, WBDest, WBValue, retire_count, wb_timeout, the wait counter and the latched dest/wb_en.
REQ-032 Reset in LOAD_WAIT SHALL abort the pending load with no write, and stall=0 from the following cycle.
REQ-033 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-034 ALU op: mem_valid=1, wb_en_in=1, mem_r_en_in=0, dest_in=3, alu_res_in=32'h1234 -> next cycle WBWriteEnable=1, WBDest=3, WBValue=32'h1234, retire_count=1; WBWriteEnable=0 the cycle after.
REQ-035 Load, 3-cycle wait: load with dest_in=7 and rvalid asserted 3 cycles later with mem_rdata=32'hDEADBEEF -> stall=1 for 3 cycles, then WBDest=7, WBValue=32'hDEADBEEF, single-cycle write.
REQ-036 Load, same-cycle data: mem_r_en_in=1 with mem_rvalid=1 -> stall stays 0 and the write occurs on the next edge.
REQ-037 Timeout: TIMEOUT=4 and a load with no rvalid -> no write, wb_timeout=1 (sticky), retire_count+1, IDLE; a subsequent ALU op is written normally.
REQ-038 Reset in LOAD_WAIT, with mem_rvalid asserted in the same cycle -> no write, all outputs 0, state IDLE.
REQ-039 Counter wrap and no-write retire: preload 16'hFFFF retires, then issue a store (wb_en_in=0) -> retire_count=0 and WBWriteEnable stays 0.
